alu_arbiter: RTL and testbench

- Shares the single combinational ALU between NUM_REQ requesters (e.g. scalar CPU EX stage, VPU scalar-operand path, address-generation helper).
- Round-robin arbitration with a valid/ready handshake per requester.
- Drives the ALU operator and operand inputs, captures the ALU result into a one-entry response register, and returns it tagged with the requester index.

---
 rtl/alu_arbiter_if.sv | 74 +++++++
 rtl/alu_arbiter.sv | 141 ++++++++++++++
 tb/tb_alu_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Operator encoding shared by the arbiter, its requesters and the ALU, plus
// the bundle of request / ALU / response signals around the arbiter.
// The perf-counter signals exist only when ALU_ARB_PERF_EN is defined.

package alu_arbiter_pkg;

  typedef enum logic [3:0] {
    _ADD = 4'd0,
    _SUB = 4'd1,
    _XOR = 4'd2,
    _OR  = 4'd3,
    _AND = 4'd4,
    _SLL = 4'd5,
    _SRL = 4'd6,
    _SRA = 4'd7,
    _LT  = 4'd8,
    _LTU = 4'd9
  } OPERATOR_t;

endpackage

interface alu_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  import alu_arbiter_pkg::*;

  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  OPERATOR_t [NUM_REQ-1:0]  req_op_i;
  logic [NUM_REQ-1:0][31:0] req_operand1_i;
  logic [NUM_REQ-1:0][31:0] req_operand2_i;

  OPERATOR_t                alu_op_o;
  logic [31:0]              alu_operand1_o;
  logic [31:0]              alu_operand2_o;
  logic [31:0]              alu_result_i;

  logic                     rsp_valid_o;
  logic                     rsp_ready_i;
  logic [ID_W-1:0]          rsp_id_o;
  logic [31:0]              rsp_result_o;

`ifdef ALU_ARB_PERF_EN
  logic [NUM_REQ-1:0][31:0] perf_grant_cnt_o;
  logic [31:0]              perf_stall_cnt_o;
  logic                     perf_clr_i;
`endif

  // Requesters, response consumer and the ALU itself sit on this side.
  modport master (
`ifdef ALU_ARB_PERF_EN
    output perf_clr_i,
    input  perf_grant_cnt_o, perf_stall_cnt_o,
`endif
    output req_valid_i, req_op_i, req_operand1_i, req_operand2_i,
    output alu_result_i, rsp_ready_i,
    input  req_ready_o, alu_op_o, alu_operand1_o, alu_operand2_o,
    input  rsp_valid_o, rsp_id_o, rsp_result_o
  );

  // The arbiter sits on this side.
  modport slave (
`ifdef ALU_ARB_PERF_EN
    input  perf_clr_i,
    output perf_grant_cnt_o, perf_stall_cnt_o,
`endif
    input  req_valid_i, req_op_i, req_operand1_i, req_operand2_i,
    input  alu_result_i, rsp_ready_i,
    output req_ready_o, alu_op_o, alu_operand1_o, alu_operand2_o,
    output rsp_valid_o, rsp_id_o, rsp_result_o
  );

endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ
// requesters. The granted request drives the ALU in the accept cycle and the
// result is captured into a one-entry response register tagged with the
// requester index. Optional perf counters: define ALU_ARB_PERF_EN.
//
// state | meaning
// ------+-------------------------------------------------
// EMPTY | response register free, any request may be taken
// FULL  | response held (rsp_valid_o=1) until rsp_ready_i

module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [31:0]        rsp_result_q, rsp_result_d;

  logic               can_accept;
  logic               grant_valid;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    grant_next;
  int                 cand;

  logic [NUM_REQ-1:0] ready;
  OPERATOR_t          alu_op;
  logic [31:0]        alu_operand1;
  logic [31:0]        alu_operand2;

  // A reset cycle never accepts; a full register frees up when drained
  // in the same cycle, which gives back-to-back throughput.
  assign can_accept = !rst &&
                      ((state_q == EMPTY) || (bus.rsp_ready_i && (state_q == FULL)));

  // Round-robin search starting at rr_ptr_q, wrapping past NUM_REQ-1.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    if (can_accept) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = int'(rr_ptr_q) + k;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
        if (!grant_valid && bus.req_valid_i[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = ID_W'(cand);
        end
      end
    end
  end

  assign grant_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  // Ready and ALU drive; ALU inputs sit at a constant idle value without a grant.
  always_comb begin
    ready        = '0;
    alu_op       = _ADD;
    alu_operand1 = '0;
    alu_operand2 = '0;
    if (grant_valid) begin
      ready[grant_idx] = 1'b1;
      alu_op           = bus.req_op_i[grant_idx];
      alu_operand1     = bus.req_operand1_i[grant_idx];
      alu_operand2     = bus.req_operand2_i[grant_idx];
    end
  end

  assign bus.req_ready_o    = ready;
  assign bus.alu_op_o       = alu_op;
  assign bus.alu_operand1_o = alu_operand1;
  assign bus.alu_operand2_o = alu_operand2;

  // Next state, response capture and pointer advance (grant implies transfer).
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    case (state_q)
      EMPTY: if (grant_valid) state_d = FULL;
      FULL:  if (!grant_valid && bus.rsp_ready_i) state_d = EMPTY;
    endcase
    if (grant_valid) begin
      rsp_result_d = bus.alu_result_i;
      rsp_id_d     = grant_idx;
      rr_ptr_d     = grant_next;
    end
  end

  // State and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      rr_ptr_q     <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign bus.rsp_valid_o  = (state_q == FULL);
  assign bus.rsp_id_o     = rsp_id_q;
  assign bus.rsp_result_o = rsp_result_q;

`ifdef ALU_ARB_PERF_EN
  logic [NUM_REQ-1:0][31:0] grant_cnt_q;
  logic [31:0]              stall_cnt_q;

  // Transfer and stall counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || bus.perf_clr_i) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (grant_valid) grant_cnt_q[grant_idx] <= grant_cnt_q[grant_idx] + 32'd1;
      if ((|bus.req_valid_i) && !grant_valid) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.perf_grant_cnt_o = grant_cnt_q;
  assign bus.perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a 2-requester and a 4-requester instance,
// each with its own behavioural ALU on the result input.

module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.NUM_REQ(2)) if2 ();
  alu_arbiter_if #(.NUM_REQ(4)) if4 ();

  alu_arbiter #(.NUM_REQ(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
  alu_arbiter #(.NUM_REQ(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

  function automatic logic [31:0] alu_f(OPERATOR_t op, logic [31:0] a, logic [31:0] b);
    case (op)
      _ADD:    return a + b;
      _SUB:    return a - b;
      _XOR:    return a ^ b;
      _OR:     return a | b;
      _AND:    return a & b;
      _SLL:    return a << b[4:0];
      _SRL:    return a >> b[4:0];
      _SRA:    return $unsigned($signed(a) >>> b[4:0]);
      _LT:     return {31'b0, ($signed(a) < $signed(b))};
      _LTU:    return {31'b0, (a < b)};
      default: return 32'd0;
    endcase
  endfunction

  assign if2.alu_result_i = alu_f(if2.alu_op_o, if2.alu_operand1_o, if2.alu_operand2_o);
  assign if4.alu_result_i = alu_f(if4.alu_op_o, if4.alu_operand1_o, if4.alu_operand2_o);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    if2.req_valid_i = '0;
    if2.rsp_ready_i = 1'b0;
    if4.req_valid_i = '0;
    if4.rsp_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if2.req_op_i[i] = _ADD;
      if2.req_operand1_i[i] = '0;
      if2.req_operand2_i[i] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      if4.req_op_i[i] = _ADD;
      if4.req_operand1_i[i] = '0;
      if4.req_operand2_i[i] = '0;
    end
`ifdef ALU_ARB_PERF_EN
    if2.perf_clr_i = 1'b0;
    if4.perf_clr_i = 1'b0;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    if2.req_valid_i = 2'b11;
    if2.req_operand1_i[0] = 32'd9;
    if2.req_operand1_i[1] = 32'd9;
    tick();
    tick();
    settle();
    checks++; if (if2.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b exp 0", if2.rsp_valid_o); end
    checks++; if (if2.rsp_id_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_id: got %0d exp 0", if2.rsp_id_o); end
    checks++; if (if2.rsp_result_o !== 32'd0) begin errors++; $display("FAIL reset_rsp_result: got %0h exp 0", if2.rsp_result_o); end
    checks++; if (if2.req_ready_o !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b exp 00", if2.req_ready_o); end
    checks++; if (if2.alu_op_o !== _ADD || if2.alu_operand1_o !== 32'd0 || if2.alu_operand2_o !== 32'd0) begin
      errors++; $display("FAIL reset_alu_idle: got op %0d a %0h b %0h exp 0 0 0", if2.alu_op_o, if2.alu_operand1_o, if2.alu_operand2_o);
    end
    checks++; if (if4.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset4_rsp_valid: got %0b exp 0", if4.rsp_valid_o); end
    rst = 1'b0;
    clear_inputs();
    tick();
  endtask

  task automatic test_single();
    if2.req_valid_i = 2'b01;
    if2.req_op_i[0] = _ADD;
    if2.req_operand1_i[0] = 32'd5;
    if2.req_operand2_i[0] = 32'd7;
    if2.rsp_ready_i = 1'b1;
    settle();
    checks++; if (if2.req_ready_o !== 2'b01) begin errors++; $display("FAIL single_ready: got %b exp 01", if2.req_ready_o); end
    checks++; if (if2.alu_op_o !== _ADD || if2.alu_operand1_o !== 32'd5 || if2.alu_operand2_o !== 32'd7) begin
      errors++; $display("FAIL single_alu_drive: got op %0d a %0d b %0d exp 0 5 7", if2.alu_op_o, if2.alu_operand1_o, if2.alu_operand2_o);
    end
    tick();
    if2.req_valid_i = 2'b00;
    settle();
    checks++; if (if2.rsp_valid_o !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %0b exp 1", if2.rsp_valid_o); end
    checks++; if (if2.rsp_id_o !== 1'b0) begin errors++; $display("FAIL single_rsp_id: got %0d exp 0", if2.rsp_id_o); end
    checks++; if (if2.rsp_result_o !== 32'd12) begin errors++; $display("FAIL single_rsp_result: got %0d exp 12", if2.rsp_result_o); end
    tick();
    settle();
    checks++; if (if2.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL single_drain: got %0b exp 0", if2.rsp_valid_o); end
  endtask

  task automatic test_alternate();
    logic [1:0]  exp_rdy [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    logic        exp_id  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] exp_res [6] = '{32'd0, 32'd7, 32'hFF, 32'd7, 32'hFF, 32'd7};
    do_reset();
    if2.req_op_i[0] = _SUB;
    if2.req_operand1_i[0] = 32'd10;
    if2.req_operand2_i[0] = 32'd3;
    if2.req_op_i[1] = _XOR;
    if2.req_operand1_i[1] = 32'hF0;
    if2.req_operand2_i[1] = 32'h0F;
    if2.req_valid_i = 2'b11;
    if2.rsp_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      settle();
      checks++; if (if2.req_ready_o !== exp_rdy[k]) begin errors++; $display("FAIL alt_ready[%0d]: got %b exp %b", k, if2.req_ready_o, exp_rdy[k]); end
      if (k > 0) begin
        checks++; if (if2.rsp_valid_o !== 1'b1 || if2.rsp_id_o !== exp_id[k] || if2.rsp_result_o !== exp_res[k]) begin
          errors++; $display("FAIL alt_rsp[%0d]: got v%0b id %0d res %0h exp v1 id %0d res %0h", k, if2.rsp_valid_o, if2.rsp_id_o, if2.rsp_result_o, exp_id[k], exp_res[k]);
        end
      end
      tick();
    end
    if2.req_valid_i = 2'b00;
    settle();
    checks++; if (if2.rsp_valid_o !== 1'b1 || if2.rsp_id_o !== 1'b1 || if2.rsp_result_o !== 32'hFF) begin
      errors++; $display("FAIL alt_last: got v%0b id %0d res %0h exp v1 id 1 res ff", if2.rsp_valid_o, if2.rsp_id_o, if2.rsp_result_o);
    end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    if2.req_op_i[0] = _ADD;
    if2.req_operand1_i[0] = 32'd1;
    if2.req_operand2_i[0] = 32'd2;
    if2.req_op_i[1] = _SLL;
    if2.req_operand1_i[1] = 32'd1;
    if2.req_operand2_i[1] = 32'd4;
    if2.req_valid_i = 2'b11;
    if2.rsp_ready_i = 1'b1;
    settle();
    checks++; if (if2.req_ready_o !== 2'b01) begin errors++; $display("FAIL bp_first_ready: got %b exp 01", if2.req_ready_o); end
    tick();
    if2.req_valid_i = 2'b10;
    if2.rsp_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      settle();
      checks++; if (if2.req_ready_o !== 2'b00 || if2.rsp_valid_o !== 1'b1 || if2.rsp_id_o !== 1'b0 || if2.rsp_result_o !== 32'd3) begin
        errors++; $display("FAIL bp_hold[%0d]: got rdy %b v%0b id %0d res %0d exp rdy 00 v1 id 0 res 3", k, if2.req_ready_o, if2.rsp_valid_o, if2.rsp_id_o, if2.rsp_result_o);
      end
      tick();
    end
    if2.rsp_ready_i = 1'b1;
    settle();
    checks++; if (if2.req_ready_o !== 2'b10) begin errors++; $display("FAIL bp_release_ready: got %b exp 10", if2.req_ready_o); end
    checks++; if (if2.alu_op_o !== _SLL || if2.alu_operand2_o !== 32'd4) begin
      errors++; $display("FAIL bp_release_alu: got op %0d b %0d exp 5 4", if2.alu_op_o, if2.alu_operand2_o);
    end
    tick();
    if2.req_valid_i = 2'b00;
    settle();
    checks++; if (if2.rsp_valid_o !== 1'b1 || if2.rsp_id_o !== 1'b1 || if2.rsp_result_o !== 32'd16) begin
      errors++; $display("FAIL bp_next_rsp: got v%0b id %0d res %0d exp v1 id 1 res 16", if2.rsp_valid_o, if2.rsp_id_o, if2.rsp_result_o);
    end
    tick();
    settle();
    checks++; if (if2.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL bp_drain: got %0b exp 0", if2.rsp_valid_o); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if4.req_op_i[i] = _ADD;
      if4.req_operand1_i[i] = i;
      if4.req_operand2_i[i] = 32'd100;
    end
    if4.rsp_ready_i = 1'b1;
    if4.req_valid_i = 4'b1000;
    settle();
    checks++; if (if4.req_ready_o !== 4'b1000) begin errors++; $display("FAIL wrap_g3: got %b exp 1000", if4.req_ready_o); end
    tick();
    if4.req_valid_i = 4'b0110;
    settle();
    checks++; if (if4.req_ready_o !== 4'b0010) begin errors++; $display("FAIL wrap_g1: got %b exp 0010", if4.req_ready_o); end
    checks++; if (if4.rsp_id_o !== 2'd3 || if4.rsp_result_o !== 32'd103) begin
      errors++; $display("FAIL wrap_rsp3: got id %0d res %0d exp id 3 res 103", if4.rsp_id_o, if4.rsp_result_o);
    end
    tick();
    if4.req_valid_i = 4'b0100;
    settle();
    checks++; if (if4.req_ready_o !== 4'b0100) begin errors++; $display("FAIL wrap_g2: got %b exp 0100", if4.req_ready_o); end
    checks++; if (if4.rsp_id_o !== 2'd1 || if4.rsp_result_o !== 32'd101) begin
      errors++; $display("FAIL wrap_rsp1: got id %0d res %0d exp id 1 res 101", if4.rsp_id_o, if4.rsp_result_o);
    end
    tick();
    if4.req_valid_i = 4'b1111;
    settle();
    checks++; if (if4.req_ready_o !== 4'b1000) begin errors++; $display("FAIL wrap_ptr3: got %b exp 1000", if4.req_ready_o); end
    checks++; if (if4.rsp_id_o !== 2'd2 || if4.rsp_result_o !== 32'd102) begin
      errors++; $display("FAIL wrap_rsp2: got id %0d res %0d exp id 2 res 102", if4.rsp_id_o, if4.rsp_result_o);
    end
    tick();
    if4.req_valid_i = 4'b0000;
    settle();
    checks++; if (if4.rsp_id_o !== 2'd3 || if4.rsp_result_o !== 32'd103) begin
      errors++; $display("FAIL wrap_rsp3b: got id %0d res %0d exp id 3 res 103", if4.rsp_id_o, if4.rsp_result_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    if2.req_op_i[0] = _LT;
    if2.req_operand1_i[0] = 32'hFFFF_FFFF;
    if2.req_operand2_i[0] = 32'd1;
    if2.req_op_i[1] = _ADD;
    if2.req_operand1_i[1] = 32'd2;
    if2.req_operand2_i[1] = 32'd3;
    if2.req_valid_i = 2'b01;
    if2.rsp_ready_i = 1'b0;
    settle();
    checks++; if (if2.req_ready_o !== 2'b01) begin errors++; $display("FAIL rmid_accept: got %b exp 01", if2.req_ready_o); end
    tick();
    if2.req_valid_i = 2'b10;
    if2.rsp_ready_i = 1'b1;
    rst = 1'b1;
    settle();
    checks++; if (if2.rsp_valid_o !== 1'b1 || if2.rsp_result_o !== 32'd1) begin
      errors++; $display("FAIL rmid_pending_lt: got v%0b res %0d exp v1 res 1", if2.rsp_valid_o, if2.rsp_result_o);
    end
    checks++; if (if2.req_ready_o !== 2'b00) begin errors++; $display("FAIL rmid_no_accept: got %b exp 00", if2.req_ready_o); end
    tick();
    rst = 1'b0;
    if2.req_valid_i = 2'b11;
    settle();
    checks++; if (if2.rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_dropped: got %0b exp 0", if2.rsp_valid_o); end
    checks++; if (if2.req_ready_o !== 2'b01) begin errors++; $display("FAIL rmid_ptr0: got %b exp 01", if2.req_ready_o); end
    tick();
    if2.req_valid_i = 2'b10;
    settle();
    checks++; if (if2.req_ready_o !== 2'b10) begin errors++; $display("FAIL rmid_req1: got %b exp 10", if2.req_ready_o); end
    tick();
    if2.req_valid_i = 2'b00;
    settle();
    checks++; if (if2.rsp_valid_o !== 1'b1 || if2.rsp_id_o !== 1'b1 || if2.rsp_result_o !== 32'd5) begin
      errors++; $display("FAIL rmid_rsp1: got v%0b id %0d res %0d exp v1 id 1 res 5", if2.rsp_valid_o, if2.rsp_id_o, if2.rsp_result_o);
    end
    tick();
  endtask

`ifdef ALU_ARB_PERF_EN
  task automatic test_perf();
    do_reset();
    if2.rsp_ready_i = 1'b1;
    if2.req_valid_i = 2'b01;
    for (int k = 0; k < 3; k++) tick();
    if2.req_valid_i = 2'b10;
    for (int k = 0; k < 2; k++) tick();
    if2.rsp_ready_i = 1'b0;
    if2.req_valid_i = 2'b01;
    for (int k = 0; k < 4; k++) tick();
    if2.req_valid_i = 2'b00;
    settle();
    checks++; if (if2.perf_grant_cnt_o[0] !== 32'd3) begin errors++; $display("FAIL perf_grant0: got %0d exp 3", if2.perf_grant_cnt_o[0]); end
    checks++; if (if2.perf_grant_cnt_o[1] !== 32'd2) begin errors++; $display("FAIL perf_grant1: got %0d exp 2", if2.perf_grant_cnt_o[1]); end
    checks++; if (if2.perf_stall_cnt_o !== 32'd4) begin errors++; $display("FAIL perf_stall: got %0d exp 4", if2.perf_stall_cnt_o); end
    tick();
    if2.rsp_ready_i = 1'b1;
    if2.req_valid_i = 2'b01;
    if2.perf_clr_i = 1'b1;
    settle();
    checks++; if (if2.req_ready_o !== 2'b01) begin errors++; $display("FAIL perf_clr_xfer: got %b exp 01", if2.req_ready_o); end
    tick();
    if2.perf_clr_i = 1'b0;
    if2.req_valid_i = 2'b00;
    settle();
    checks++; if (if2.perf_grant_cnt_o !== '0 || if2.perf_stall_cnt_o !== 32'd0) begin
      errors++; $display("FAIL perf_clear: got g0 %0d g1 %0d s %0d exp 0 0 0", if2.perf_grant_cnt_o[0], if2.perf_grant_cnt_o[1], if2.perf_stall_cnt_o);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_wrap();
    test_reset_mid();
`ifdef ALU_ARB_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
